rim_maze_solver: RTL and testbench
==================================

Name: rim_maze_solver

Overview:
- Rat-in-maze solver for an 8x8 grid of cells.
- Loads the maze one row per `in_valid` beat, then runs a depth-first search with backtracking from cell (0,0) to cell (7,7).
- Streams the found path, one coordinate per cycle, on `out_row`/`out_col` qualified by `out_valid`.
- Standalone compute block; the upstream source supplies rows and the downstream sink consumes a coordinate stream.

Parameters:
- None. The grid is fixed at 8x8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- maze  input  8  one maze row; bit 7 = column 0 … bit 0 = column 7; 1 = open, 0 = wall.
- in_valid  input  1  qualifies `maze`; the k-th asserted cycle carries row k (k = 0..7).
- out_valid  output  1  high while a path coordinate is being driven.
- out_row  output  3  row of the current path cell.
- out_col  output  3  column of the current path cell.

Behaviour:
- Interface: one clock (`clk`); reset `rst_n` is asynchronous and active-low.
- Reset values: `out_valid`=0, `out_row`=0, `out_col`=0; row counter, stack, visited map and FSM cleared; FSM in IDLE.
- Reset asserted mid-operation aborts immediately. After release, the block waits for a fresh 8-row load.
- FSM states: IDLE, LOAD, SEARCH, OUTPUT.
- IDLE / LOAD:
  - Each cycle with `in_valid`=1 stores `maze` into row[cnt] and increments `cnt`.
  - `in_valid` need not be contiguous; gaps of any length are allowed.
  - The cycle that stores row 7 moves the FSM to SEARCH.
- Cells are 1-bit open flags plus a 1-bit visited flag (64 each).
- SEARCH (one DFS step per cycle):
  - First step: if cell (0,0) or (7,7) is a wall, go to IDLE with no output. Otherwise push (0,0) onto the stack and mark it visited.
  - Each later cycle, with top-of-stack (r,c), take the first open, unvisited, in-bounds neighbour in fixed priority: right (r,c+1), down (r+1,c), left (r,c-1), up (r-1,c). Push it and mark it visited.
  - If no neighbour qualifies, pop (backtrack); visited flags stay set.
  - When the pushed cell is (7,7), go to OUTPUT.
  - If a pop empties the stack, no path exists: go to IDLE with no output.
- Stack: 64 entries x 6 bits ({row,col}) plus a 7-bit depth pointer. The stack holds the current simple path from (0,0).
- OUTPUT:
  - Starting the cycle after (7,7) is pushed, drive stack entries bottom to top, one per cycle, with `out_valid`=1.
  - First beat is (0,0); last beat is (7,7).
  - Beat count equals stack depth (minimum 15). Beats are contiguous.
  - Then `out_valid`=0, outputs return to 0, FSM goes to IDLE.
- Outputs are registered. `out_row`/`out_col` are 0 whenever `out_valid`=0.
- `in_valid` during SEARCH/OUTPUT is ignored; no row is stored.
- Boundary neighbours outside 0..7 are never considered; row/column arithmetic never wraps.
- Latency: search length is data dependent, at most 128 steps (64 pushes + 64 pops). No backpressure.

Optional Feature:
- RIM_PATH_LEN_EN:
  - When defined, adds output port `out_len` [6:0].
  - `out_len` holds the number of path cells (stack depth) on every `out_valid` beat and is 0 otherwise; reset value 0.
- When not defined: no `out_len` port and no extra logic; behaviour otherwise identical.

Test Plan:
- Dead-end maze:
  - Stimulus: rows 0x80, 0xF0, 0x50, 0x58, 0x4C, 0x46, 0x42, 0x03, each on a single `in_valid` pulse separated by idle cycles.
  - Required output: exactly 15 contiguous beats (0,0),(1,0),(1,1),(1,2),(1,3),(2,3),(3,3),(3,4),(4,4),(4,5),(5,5),(5,6),(6,6),(7,6),(7,7).
  - The column-1 dead end must not appear in the output.
- All-open maze (eight rows of 0xFF, back-to-back):
  - Required output: (0,0)..(0,7) then (1,7)..(7,7); 15 beats.
  - With RIM_PATH_LEN_EN, `out_len`=15 on every beat.
- Blocked start (row 0 = 0x7F, other rows 0xFF): no `out_valid` ever.
  - A following valid load is then solved normally.
- No path (row 4 = 0x00, other rows 0xFF): search exhausts, `out_valid` stays 0, FSM returns to IDLE.
- Reset asserted during OUTPUT beat 5: `out_valid`/`out_row`/`out_col` go to 0 immediately.
  - A reload of the dead-end maze reproduces the full 15-beat path.
- `in_valid` pulses during SEARCH and OUTPUT: ignored; the output path is unchanged.

Source files
------------

// File: rtl/rim_maze_solver_if.sv
// ============================================================================
// Module  : rim_maze_solver_if
// Brief   : Row-load / path-stream bundle for rim_maze_solver.
//           out_len exists only when RIM_PATH_LEN_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface rim_maze_solver_if;
    logic [7:0] maze;
    logic       in_valid;
    logic       out_valid;
    logic [2:0] out_row;
    logic [2:0] out_col;
`ifdef RIM_PATH_LEN_EN
    logic [6:0] out_len;

    modport master (output maze, in_valid, input out_valid, out_row, out_col, out_len);
    modport slave  (input maze, in_valid, output out_valid, out_row, out_col, out_len);
`else
    modport master (output maze, in_valid, input out_valid, out_row, out_col);
    modport slave  (input maze, in_valid, output out_valid, out_row, out_col);
`endif
endinterface

`default_nettype wire

// File: rtl/rim_maze_solver.sv
// ============================================================================
// Module  : rim_maze_solver
// Brief   : 8x8 rat-in-maze DFS solver; loads 8 rows, streams (0,0)->(7,7) path.
//           Optional macro RIM_PATH_LEN_EN adds the out_len port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rim_maze_solver (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rim_maze_solver_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SEARCH = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    localparam logic [5:0] c_GOAL = 6'd63;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [63:0] r_open;     // cell index = {row, col}
    logic [63:0] r_visited;
    logic [5:0] r_stack [64];
    logic [6:0] r_sp;        // depth: number of valid stack entries
    logic [6:0] r_out_idx;
    logic       r_out_valid;
    logic [2:0] r_out_row;
    logic [2:0] r_out_col;
`ifdef RIM_PATH_LEN_EN
    logic [6:0] r_out_len;
`endif

    logic [7:0] w_maze_rev;
    logic [5:0] w_top;
    logic [2:0] w_r;
    logic [2:0] w_c;
    logic [5:0] w_right;
    logic [5:0] w_down;
    logic [5:0] w_left;
    logic [5:0] w_up;
    logic       w_ok_right;
    logic       w_ok_down;
    logic       w_ok_left;
    logic       w_ok_up;
    logic       w_has_next;
    logic [5:0] w_next;

    // maze bit 7 is column 0, so reverse to make bit index equal to column
    always_comb begin
        w_maze_rev = '0;
        for (int c = 0; c < 8; c++) begin
            w_maze_rev[c] = bus.maze[7 - c];
        end
    end

    assign w_top   = r_stack[r_sp[5:0] - 6'd1];
    assign w_r     = w_top[5:3];
    assign w_c     = w_top[2:0];
    assign w_right = {w_r, w_c + 3'd1};
    assign w_down  = {w_r + 3'd1, w_c};
    assign w_left  = {w_r, w_c - 3'd1};
    assign w_up    = {w_r - 3'd1, w_c};

    // Bounds tests come first so a wrapped index is never acted upon
    assign w_ok_right = (w_c != 3'd7) && r_open[w_right] && !r_visited[w_right];
    assign w_ok_down  = (w_r != 3'd7) && r_open[w_down]  && !r_visited[w_down];
    assign w_ok_left  = (w_c != 3'd0) && r_open[w_left]  && !r_visited[w_left];
    assign w_ok_up    = (w_r != 3'd0) && r_open[w_up]    && !r_visited[w_up];

    always_comb begin
        w_has_next = 1'b1;
        w_next     = '0;
        if (w_ok_right)     w_next = w_right;
        else if (w_ok_down) w_next = w_down;
        else if (w_ok_left) w_next = w_left;
        else if (w_ok_up)   w_next = w_up;
        else                w_has_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_open      <= '0;
            r_visited   <= '0;
            r_sp        <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
`ifdef RIM_PATH_LEN_EN
            r_out_len   <= '0;
`endif
            for (int i = 0; i < 64; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (bus.in_valid) begin
                        r_open[{r_cnt, 3'b000} +: 8] <= w_maze_rev;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state   <= S_SEARCH;
                            r_sp      <= '0;
                            r_visited <= '0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_SEARCH: begin
                    if (r_sp == 7'd0) begin
                        if (!r_open[0] || !r_open[c_GOAL]) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_stack[0]   <= 6'd0;
                            r_sp         <= 7'd1;
                            r_visited[0] <= 1'b1;
                        end
                    end else if (w_has_next) begin
                        r_stack[r_sp[5:0]] <= w_next;
                        r_sp               <= r_sp + 7'd1;
                        r_visited[w_next]  <= 1'b1;
                        if (w_next == c_GOAL) begin
                            r_state   <= S_OUTPUT;
                            r_out_idx <= '0;
                        end
                    end else begin
                        r_sp <= r_sp - 7'd1;
                        if (r_sp == 7'd1) r_state <= S_IDLE;
                    end
                end
                S_OUTPUT: begin
                    if (r_out_idx < r_sp) begin
                        r_out_valid <= 1'b1;
                        {r_out_row, r_out_col} <= r_stack[r_out_idx[5:0]];
                        r_out_idx   <= r_out_idx + 7'd1;
`ifdef RIM_PATH_LEN_EN
                        r_out_len   <= r_sp;
`endif
                    end else begin
                        r_out_valid <= 1'b0;
                        r_out_row   <= '0;
                        r_out_col   <= '0;
`ifdef RIM_PATH_LEN_EN
                        r_out_len   <= '0;
`endif
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_row   = r_out_row;
    assign bus.out_col   = r_out_col;
`ifdef RIM_PATH_LEN_EN
    assign bus.out_len   = r_out_len;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rim_maze_solver.sv
// ============================================================================
// Module  : tb_rim_maze_solver
// Brief   : Table-driven, scoreboard-checked bench for rim_maze_solver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rim_maze_solver;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    rim_maze_solver_if bus();

    rim_maze_solver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] rows;   // row 0 in the top byte
        logic [7:0]  gap;
        logic [7:0]  npath;
        logic [89:0] path;   // 15 x {row,col}, first beat in the top bits
    } vec_t;

    localparam logic [89:0] P_DEAD = {6'o00, 6'o10, 6'o11, 6'o12, 6'o13, 6'o23, 6'o33, 6'o34,
                                      6'o44, 6'o45, 6'o55, 6'o56, 6'o66, 6'o76, 6'o77};
    localparam logic [89:0] P_OPEN = {6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07,
                                      6'o17, 6'o27, 6'o37, 6'o47, 6'o57, 6'o67, 6'o77};
    localparam logic [89:0] P_LSHP = {6'o00, 6'o10, 6'o20, 6'o30, 6'o40, 6'o50, 6'o60, 6'o70,
                                      6'o71, 6'o72, 6'o73, 6'o74, 6'o75, 6'o76, 6'o77};
    localparam logic [63:0] M_DEAD = 64'h80F0_5058_4C46_4203;
    localparam logic [63:0] M_OPEN = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int NV = 6;
    vec_t vecs [NV];
    string vnames [NV];

    logic [5:0] exp_q [$];
    logic [5:0] e;
    int   checks     = 0;
    int   failures   = 0;
    int   beat_cnt   = 0;
    int   cur_len    = 0;
    logic prev_valid = 1'b0;

    // Scoreboard monitor: every beat pops one expected cell
    always @(negedge clk) begin
        if (bus.out_valid) begin
            beat_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat got=(%0d,%0d) want=no beat", bus.out_row, bus.out_col);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_row, bus.out_col} !== e) begin
                    failures++;
                    $display("FAIL path_beat got=(%0d,%0d) want=(%0d,%0d)",
                             bus.out_row, bus.out_col, e[5:3], e[2:0]);
                end
            end
`ifdef RIM_PATH_LEN_EN
            checks++;
            if (bus.out_len !== 7'(cur_len)) begin
                failures++;
                $display("FAIL out_len_beat got=%0d want=%0d", bus.out_len, cur_len);
            end
`endif
        end else begin
            checks++;
            if (bus.out_row !== 3'd0 || bus.out_col !== 3'd0) begin
                failures++;
                $display("FAIL idle_zero got=(%0d,%0d) want=(0,0)", bus.out_row, bus.out_col);
            end
`ifdef RIM_PATH_LEN_EN
            checks++;
            if (bus.out_len !== 7'd0) begin
                failures++;
                $display("FAIL out_len_idle got=%0d want=0", bus.out_len);
            end
`endif
            if (prev_valid && exp_q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL path_gap got=burst ended want=%0d more beats", exp_q.size());
            end
        end
        prev_valid = bus.out_valid;
    end

    task automatic load_maze(input logic [63:0] rows, input int gap);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.maze     = rows[63 - 8*k -: 8];
            if (gap > 0) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                bus.maze     = 8'h00;
                repeat (gap - 1) @(posedge clk);
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.maze     = 8'h00;
    endtask

    task automatic expect_path(input vec_t v);
        cur_len = int'(v.npath);
        for (int i = 0; i < int'(v.npath); i++) begin
            exp_q.push_back(v.path[89 - 6*i -: 6]);
        end
    endtask

    task automatic wait_done(input string name, input int start, input int npath);
        int t;
        t = 0;
        if (npath > 0) begin
            while ((exp_q.size() != 0 || bus.out_valid) && t < 600) begin
                @(posedge clk); #1;
                t++;
            end
            repeat (4) @(posedge clk);
        end else begin
            repeat (300) @(posedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_complete got=%0d beats missing want=0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (beat_cnt - start != npath) begin
            failures++;
            $display("FAIL %s_beats got=%0d want=%0d", name, beat_cnt - start, npath);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int start;
        start = beat_cnt;
        expect_path(v);
        load_maze(v.rows, int'(v.gap));
        wait_done(name, start, int'(v.npath));
    endtask

    initial begin
        int start;
        int n;
        int t;

        vecs[0] = '{rows: M_DEAD, gap: 8'd3, npath: 8'd15, path: P_DEAD};
        vecs[1] = '{rows: M_OPEN, gap: 8'd0, npath: 8'd15, path: P_OPEN};
        vecs[2] = '{rows: 64'h7FFF_FFFF_FFFF_FFFF, gap: 8'd0, npath: 8'd0, path: 90'd0};
        vecs[3] = '{rows: M_OPEN, gap: 8'd1, npath: 8'd15, path: P_OPEN};
        vecs[4] = '{rows: 64'hFFFF_FFFF_00FF_FFFF, gap: 8'd2, npath: 8'd0, path: 90'd0};
        vecs[5] = '{rows: 64'h8080_8080_8080_80FF, gap: 8'd0, npath: 8'd15, path: P_LSHP};
        vnames[0] = "dead_end";
        vnames[1] = "all_open";
        vnames[2] = "blocked_start";
        vnames[3] = "after_blocked";
        vnames[4] = "no_path";
        vnames[5] = "l_shape";

        bus.in_valid = 1'b0;
        bus.maze     = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_row !== 3'd0 || bus.out_col !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=v%0b (%0d,%0d) want=v0 (0,0)",
                     bus.out_valid, bus.out_row, bus.out_col);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], vnames[i]);
        end

        // Reset while beat 5 of the dead-end path is on the outputs
        expect_path(vecs[0]);
        load_maze(M_DEAD, 1);
        n = 0;
        t = 0;
        while (n < 5 && t < 600) begin
            @(posedge clk); #1;
            t++;
            if (bus.out_valid) n++;
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL reset_mid_reach got=%0d beats want=5", n);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_row !== 3'd0 || bus.out_col !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_out got=v%0b (%0d,%0d) want=v0 (0,0)",
                     bus.out_valid, bus.out_row, bus.out_col);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec(vecs[0], "reload_dead_end");

        // Stray in_valid pulses during SEARCH and the first OUTPUT beats
        start = beat_cnt;
        expect_path(vecs[1]);
        load_maze(M_OPEN, 0);
        t = 0;
        while (beat_cnt - start < 5 && t < 100) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.maze     = 8'h00;
            t++;
        end
        bus.in_valid = 1'b0;
        wait_done("ignore_in_valid", start, 15);

        run_vec(vecs[5], "after_noise");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
